program_loader: RTL

- Writer side of the instruction-memory interface.
- The CPU fetch path only reads program memory; this block fills it.
- It receives a byte stream from the chip's input pins, assembles little-endian 32-bit instruction words, and writes them to consecutive program-memory addresses.
- It holds the CPU in reset while loading, then releases it.

---
 rtl/program_loader_pkg.sv | 19 +
 rtl/program_loader_byte_assembler.sv | 49 ++++
 rtl/program_loader.sv | 135 +++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and word geometry.
package program_loader_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_ADD_WIDTH  = 8;
    localparam int BYTES_PER_WORD = DEF_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic holds_cpu(input state_t s);
        return (s == LOAD) || (s == FLUSH);
    endfunction

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Packs a strobed byte stream into little-endian words; lane 0 is bits [7:0].
module program_loader_byte_assembler #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             strobe,
    input  logic [7:0]       byte_in,
    output logic [WIDTH-1:0] word,
    output logic [IDX_W-1:0] byte_idx,
    output logic             word_ready
);

    localparam int BYTES = WIDTH / 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    logic [WIDTH-1:0] word_q;

    // word and word_ready are combinational so the completing byte can be
    // written to memory on the very next edge without an extra pipeline stage.
    always_comb begin
        // NOTE: default assignment first so no path through the block infers a latch.
        word = word_q;
        for (int i = 0; i < BYTES; i++) begin
            if (byte_idx == IDX_W'(i)) begin
                word[i*8 +: 8] = byte_in;
            end
        end
    end

    assign word_ready = strobe && (byte_idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            word_q   <= '0;
            byte_idx <= '0;
        end else if (clear) begin
            byte_idx <= '0;
        end else if (strobe) begin
            word_q   <= word;
            byte_idx <= (byte_idx == LAST_IDX) ? '0 : byte_idx + 1'b1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a byte stream into program memory as consecutive words while holding the CPU in reset.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ADD_WIDTH = DEF_ADD_WIDTH,
    parameter int DEPTH     = 2 ** ADD_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_en,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 mem_wen,
    output logic [ADD_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    output logic                 cpu_hold,
    output logic                 busy,
    output logic                 done,
    output logic [ADD_WIDTH:0]   word_count,
    output logic [7:0]           checksum,
    output logic                 err
);

    localparam int BYTES = WIDTH / 8;
    localparam int IDX_W = $clog2(BYTES);
    localparam int CNT_W = ADD_WIDTH + 1;

    state_t state, next_state;
    logic   load_en_q;
    logic   start, accept, leave, full;

    logic [WIDTH-1:0] asm_word;
    logic [IDX_W-1:0] byte_idx;
    logic             word_ready;

    // The low bits of word_count double as the write address, so the address
    // stops advancing exactly when the memory is full and can never wrap.
    assign full = (word_count == CNT_W'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        accept     = 1'b0;
        leave      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (load_en && !load_en_q) begin
                    next_state = LOAD;
                    start      = 1'b1;
                end
            end
            LOAD: begin
                if (!load_en) begin
                    next_state = FLUSH;
                    leave      = 1'b1;
                end else begin
                    accept = byte_valid;
                end
            end
            FLUSH:   next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    program_loader_byte_assembler #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_assembler (
        .clk        (clk),
        .rst        (rst),
        .clear      (start || leave),
        .strobe     (accept && !full),
        .byte_in    (byte_in),
        .word       (asm_word),
        .byte_idx   (byte_idx),
        .word_ready (word_ready)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_en_q  <= 1'b0;
            mem_wen    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            word_count <= '0;
            checksum   <= '0;
            err        <= 1'b0;
        end else begin
            load_en_q <= load_en;
            mem_wen   <= 1'b0;
            cpu_hold  <= holds_cpu(next_state);
            busy      <= holds_cpu(next_state);
            done      <= (next_state == DONE);

            if (start) begin
                word_count <= '0;
                checksum   <= '0;
                err        <= 1'b0;
                mem_addr   <= '0;
            end

            // Bytes past a full memory still count toward the checksum.
            if (accept) begin
                checksum <= checksum ^ byte_in;
                if (full) begin
                    err <= 1'b1;
                end
            end

            if (word_ready) begin
                mem_wen    <= 1'b1;
                mem_addr   <= word_count[ADD_WIDTH-1:0];
                mem_wdata  <= asm_word;
                word_count <= word_count + 1'b1;
            end

            if (leave && (byte_idx != '0)) begin
                err <= 1'b1;
            end
        end
    end

endmodule
